// File: rtl/raster_hash_pkg.sv
// Shared helpers for the jitter-hash pipeline: XOR-fold tree hash and MSAA mask decode.
package raster_hash_pkg;

    localparam int HASH_MAX    = 32;
    localparam int FOLD_IN_MAX = 128;

    localparam logic [3:0] MODE_1X  = 4'b1000;
    localparam logic [3:0] MODE_4X  = 4'b0100;
    localparam logic [3:0] MODE_16X = 4'b0010;
    localparam logic [3:0] MODE_64X = 4'b0001;

    // Callers zero-extend the key to FOLD_IN_MAX; zero bits do not change any XOR.
    function automatic logic [HASH_MAX-1:0] tree_fold(input logic [FOLD_IN_MAX-1:0] in_bits,
                                                       input int out_width);
        logic [HASH_MAX-1:0] acc;
        acc = '0;
        for (int j = 0; j < FOLD_IN_MAX; j++) begin
            for (int i = 0; i < HASH_MAX; i++) begin
                if (i == (j % out_width)) begin
                    acc[i] = acc[i] ^ in_bits[j];
                end
            end
        end
        return acc;
    endfunction

    function automatic logic mode_legal(input logic [3:0] sub);
        return $onehot(sub);
    endfunction

    function automatic logic [HASH_MAX-1:0] msaa_mask(input logic [3:0] sub, input int out_width);
        logic [HASH_MAX-1:0] ones;
        logic [HASH_MAX-1:0] mask;
        for (int i = 0; i < HASH_MAX; i++) begin
            ones[i] = (i < out_width);
        end
        case (sub)
            MODE_1X:  mask = ones;
            MODE_4X:  mask = ones >> 1;
            MODE_16X: mask = ones >> 2;
            MODE_64X: mask = ones >> 3;
            default:  mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/hash_jtree_pipe_if.sv
// Sample bus between raster stages: triangle, colour and sample location with valid/ready.
interface hash_jtree_pipe_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_U;
    logic signed [1:0][SIGFIG-1:0]                 sample_S;
    logic                                          validSamp_H;
    logic                                          readySamp_H;

    modport master (
        output tri_S, color_U, sample_S, validSamp_H,
        input  readySamp_H
    );

    modport slave (
        input  tri_S, color_U, sample_S, validSamp_H,
        output readySamp_H
    );
endinterface

// File: rtl/hash_jtree_stage.sv
// One pipeline slice: data word plus valid bit, both held when the enable is low.
module hash_jtree_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign valid_d = en_i ? valid_i : valid_q;
    assign data_d  = en_i ? data_i  : data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/hash_jtree_pipe.sv
// Jitter-hash stage: ORs a seeded, MSAA-masked XOR-fold hash of the sample position into
// its sub-pixel bits, then carries the sample through PIPE_DEPTH backpressured registers.
module hash_jtree_pipe
    import raster_hash_pkg::*;
#(
    parameter int SIGFIG         = 24,
    parameter int RADIX          = 10,
    parameter int VERTS          = 3,
    parameter int AXIS           = 3,
    parameter int COLORS         = 3,
    parameter int HASH_OUT_WIDTH = 8,
    parameter int PIPE_DEPTH     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    hash_jtree_pipe_if.slave              samp_R14,
    hash_jtree_pipe_if.master             samp_R16,
    input  logic [3:0]                    subSample_RnnnnU,
    input  logic                          jitEn_RnnnnH,
    input  logic                          frameStart_RnnnnH,
    input  logic [2*HASH_OUT_WIDTH-1:0]   seed_RnnnnU,
    output logic                          modeErr_RnnnnH
);
    localparam int HW     = HASH_OUT_WIDTH;
    localparam int KEY_W  = 2 * (SIGFIG - 4);
    localparam int SHIFT  = RADIX - HW;
    localparam int TRI_W  = VERTS * AXIS * SIGFIG;
    localparam int COL_W  = COLORS * SIGFIG;
    localparam int DATA_W = TRI_W + COL_W + 2 * SIGFIG;

    logic [2*HW-1:0] seed_q, seed_d;
    logic            mode_err_q, mode_err_d;
    logic            adv;

    assign seed_d     = frameStart_RnnnnH ? seed_RnnnnU : seed_q;
    assign mode_err_d = mode_err_q | ~mode_legal(subSample_RnnnnU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q     <= '0;
            mode_err_q <= 1'b0;
        end else begin
            seed_q     <= seed_d;
            mode_err_q <= mode_err_d;
        end
    end

    assign modeErr_RnnnnH = mode_err_q;

    logic [SIGFIG-1:0] s0, s1;
    assign s0 = samp_R14.sample_S[0];
    assign s1 = samp_R14.sample_S[1];

    // The low four bits are excluded so samples within one sub-pixel cell hash alike.
    logic [KEY_W-1:0] hx_in, hy_in;
    assign hx_in = {s1[SIGFIG-1:4], s0[SIGFIG-1:4]};
    assign hy_in = {s0[SIGFIG-1:4], s1[SIGFIG-1:4]};

    logic [HASH_MAX-1:0] fold_x, fold_y, mask;
    assign fold_x = tree_fold(FOLD_IN_MAX'(hx_in), HW);
    assign fold_y = tree_fold(FOLD_IN_MAX'(hy_in), HW);
    assign mask   = msaa_mask(subSample_RnnnnU, HW);

    logic unused_hash_hi;
    assign unused_hash_hi = ^{fold_x[HASH_MAX-1:HW], fold_y[HASH_MAX-1:HW], mask[HASH_MAX-1:HW]};

    logic [HW-1:0] jit_x, jit_y;
    assign jit_x = jitEn_RnnnnH ? ((fold_x[HW-1:0] ^ seed_q[HW-1:0])    & mask[HW-1:0]) : '0;
    assign jit_y = jitEn_RnnnnH ? ((fold_y[HW-1:0] ^ seed_q[2*HW-1:HW]) & mask[HW-1:0]) : '0;

    // Pure OR into the top HW fractional bits; the integer part never sees a carry.
    logic [SIGFIG-1:0] s0_j, s1_j;
    assign s0_j = s0 | (SIGFIG'(jit_x) << SHIFT);
    assign s1_j = s1 | (SIGFIG'(jit_y) << SHIFT);

    logic [DATA_W-1:0]   data_chain [PIPE_DEPTH+1];
    logic [PIPE_DEPTH:0] valid_chain;

    assign data_chain[0]  = {samp_R14.tri_S, samp_R14.color_U, s1_j, s0_j};
    assign valid_chain[0] = samp_R14.validSamp_H;

    generate
        for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
            hash_jtree_stage #(
                .WIDTH (DATA_W)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en_i    (adv),
                .valid_i (valid_chain[gi]),
                .data_i  (data_chain[gi]),
                .valid_o (valid_chain[gi+1]),
                .data_o  (data_chain[gi+1])
            );
        end
    endgenerate

    // Whole pipe moves in lockstep; bubbles travel with it rather than being squeezed out.
    assign adv                  = ~valid_chain[PIPE_DEPTH] | samp_R16.readySamp_H;
    assign samp_R14.readySamp_H = adv;
    assign samp_R16.validSamp_H = valid_chain[PIPE_DEPTH];
    assign {samp_R16.tri_S, samp_R16.color_U, samp_R16.sample_S} = data_chain[PIPE_DEPTH];

endmodule

// File: tb/tb_hash_jtree_pipe.sv
// Bench for hash_jtree_pipe: directed steps plus random streams against a fold/mask model.
`timescale 1ns/1ps
module tb_hash_jtree_pipe;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int HW     = 8;
    localparam int DEPTH  = 3;
    localparam int TRI_W  = VERTS * AXIS * SIGFIG;
    localparam int COL_W  = COLORS * SIGFIG;
    localparam int SEED_W = 2 * HW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]        sub;
    logic              jit_en, frame_start, mode_err;
    logic [SEED_W-1:0] seed;

    hash_jtree_pipe_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) r14 ();
    hash_jtree_pipe_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) r16 ();

    hash_jtree_pipe #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
        .HASH_OUT_WIDTH(HW), .PIPE_DEPTH(DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .samp_R14          (r14),
        .samp_R16          (r16),
        .subSample_RnnnnU  (sub),
        .jitEn_RnnnnH      (jit_en),
        .frameStart_RnnnnH (frame_start),
        .seed_RnnnnU       (seed),
        .modeErr_RnnnnH    (mode_err)
    );

    logic [TRI_W-1:0]  in_tri, o_tri;
    logic [COL_W-1:0]  in_col, o_col;
    logic [SIGFIG-1:0] in_s0, in_s1, o_s0, o_s1;
    logic              in_valid, out_ready, o_valid;

    assign r14.tri_S       = in_tri;
    assign r14.color_U     = in_col;
    assign r14.sample_S    = {in_s1, in_s0};
    assign r14.validSamp_H = in_valid;
    assign r16.readySamp_H = out_ready;
    assign o_tri   = r16.tri_S;
    assign o_col   = r16.color_U;
    assign o_s0    = r16.sample_S[0];
    assign o_s1    = r16.sample_S[1];
    assign o_valid = r16.validSamp_H;

    typedef struct {
        logic [TRI_W-1:0]  tri_v;
        logic [COL_W-1:0]  col;
        logic [SIGFIG-1:0] s0, s1;
        int                acc_cyc;
        int                stall_snap;
    } exp_t;

    exp_t q[$];
    int n_assert = 0, n_fail = 0, cyc = 0, stall_cnt = 0, n_out = 0;
    logic [SEED_W-1:0] model_seed;
    logic              model_err;
    bit   fixed_en, last_in_x, prev_stall;
    logic [SIGFIG-1:0] fixed_e0, fixed_e1, held_s0, held_s1;
    logic [TRI_W-1:0]  held_tri;
    logic [COL_W-1:0]  held_col;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Folding = XOR of successive HW-bit chunks of the key.
    function automatic logic [HW-1:0] ref_fold(input logic [63:0] key);
        logic [HW-1:0] h;
        h = '0;
        while (key != 64'd0) begin
            h   = h ^ key[HW-1:0];
            key = key >> HW;
        end
        return h;
    endfunction

    function automatic logic [SIGFIG-1:0] ref_axis(input logic [SIGFIG-1:0] s,
                                                   input logic [63:0] key,
                                                   input logic [HW-1:0] sd);
        int            sh;
        logic [HW-1:0] m, j;
        case (sub)
            4'b1000: sh = 0;
            4'b0100: sh = 1;
            4'b0010: sh = 2;
            4'b0001: sh = 3;
            default: sh = -1;
        endcase
        if (!jit_en || sh < 0) return s;
        m = {HW{1'b1}} >> sh;
        j = (ref_fold(key) ^ sd) & m;
        return s | (SIGFIG'(j) << (RADIX - HW));
    endfunction

    task automatic rand_inputs();
        in_s0 = SIGFIG'($urandom);
        in_s1 = SIGFIG'($urandom);
        for (int k = 0; k < VERTS * AXIS; k++) in_tri[k*SIGFIG +: SIGFIG] = SIGFIG'($urandom);
        for (int k = 0; k < COLORS; k++)       in_col[k*SIGFIG +: SIGFIG] = SIGFIG'($urandom);
    endtask

    // One clock: observe at the falling edge, then let the rising edge happen.
    task automatic cycle();
        logic        vo, ro;
        logic [63:0] hx, hy;
        exp_t        e;
        @(negedge clk);
        vo = o_valid;
        ro = out_ready;
        check("ready_in", 256'(r14.readySamp_H), 256'(!vo || ro));
        check("mode_err", 256'(mode_err), 256'(model_err));
        if (prev_stall) begin
            check("stall_valid", 256'(vo), 256'(1'b1));
            check("stall_s0", 256'(o_s0), 256'(held_s0));
            check("stall_s1", 256'(o_s1), 256'(held_s1));
            check("stall_tri", 256'(o_tri), 256'(held_tri));
            check("stall_col", 256'(o_col), 256'(held_col));
        end
        last_in_x = in_valid && r14.readySamp_H;
        if (last_in_x) begin
            hx = ((64'(in_s1) >> 4) << (SIGFIG - 4)) | (64'(in_s0) >> 4);
            hy = ((64'(in_s0) >> 4) << (SIGFIG - 4)) | (64'(in_s1) >> 4);
            e.tri_v = in_tri;
            e.col   = in_col;
            if (fixed_en) begin
                e.s0 = fixed_e0;
                e.s1 = fixed_e1;
            end else begin
                e.s0 = ref_axis(in_s0, hx, model_seed[HW-1:0]);
                e.s1 = ref_axis(in_s1, hy, model_seed[SEED_W-1:HW]);
            end
            e.acc_cyc    = cyc;
            e.stall_snap = stall_cnt;
            q.push_back(e);
        end
        if (vo && ro) begin
            n_out++;
            if (q.size() == 0) begin
                check("spurious_out", 256'(vo), 256'(1'b0));
            end else begin
                e = q.pop_front();
                $display("out %0d: s0=%06h s1=%06h (exp %06h %06h)", n_out, o_s0, o_s1, e.s0, e.s1);
                check("out_s0", 256'(o_s0), 256'(e.s0));
                check("out_s1", 256'(o_s1), 256'(e.s1));
                check("out_tri", 256'(o_tri), 256'(e.tri_v));
                check("out_col", 256'(o_col), 256'(e.col));
                if (stall_cnt == e.stall_snap) check("latency", 256'(cyc - e.acc_cyc), 256'(DEPTH));
            end
        end
        prev_stall = vo && !ro;
        if (prev_stall) stall_cnt++;
        held_s0 = o_s0; held_s1 = o_s1; held_tri = o_tri; held_col = o_col;
        @(posedge clk);
        if (frame_start) model_seed = seed;
        if ($countones(sub) != 1) model_err = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic send_fixed(input logic [SIGFIG-1:0] s0, s1, e0, e1);
        rand_inputs();
        in_s0 = s0; in_s1 = s1;
        fixed_en = 1'b1; fixed_e0 = e0; fixed_e1 = e1;
        in_valid = 1'b1;
        cycle();
        check("accepted", 256'(last_in_x), 256'(1'b1));
        in_valid = 1'b0;
        fixed_en = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && t < 50) begin
            cycle();
            t++;
        end
        check("drain_empty", 256'(q.size()), 256'(0));
    endtask

    task automatic run_stream(input int n, input int st_lo, input int st_hi, input bit rnd);
        int sent, t;
        sent = 0;
        t = 0;
        rand_inputs();
        while ((sent < n || q.size() != 0) && t < 400) begin
            in_valid    = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
            out_ready   = rnd ? ($urandom_range(0, 3) != 0) : !(t >= st_lo && t < st_hi);
            frame_start = rnd && ($urandom_range(0, 7) == 0);
            seed        = SEED_W'($urandom);
            if (rnd) jit_en = ($urandom_range(0, 5) != 0);
            cycle();
            if (last_in_x) begin
                sent++;
                rand_inputs();
            end
            t++;
        end
        in_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1; jit_en = 1'b1;
        check("stream_sent", 256'(sent), 256'(n));
        check("stream_empty", 256'(q.size()), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; sub = 4'b1000; jit_en = 1'b1; frame_start = 1'b0; seed = '0;
        in_valid = 1'b0; out_ready = 1'b0; in_tri = '0; in_col = '0; in_s0 = '0; in_s1 = '0;
        model_seed = '0; model_err = 1'b0; fixed_en = 1'b0; last_in_x = 1'b0; prev_stall = 1'b0;
        held_s0 = '0; held_s1 = '0; held_tri = '0; held_col = '0; fixed_e0 = '0; fixed_e1 = '0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 256'(o_valid), 256'(1'b0));
        check("rst_s0", 256'(o_s0), 256'(0));
        check("rst_s1", 256'(o_s1), 256'(0));
        check("rst_tri", 256'(o_tri), 256'(0));
        check("rst_col", 256'(o_col), 256'(0));
        check("rst_mode_err", 256'(mode_err), 256'(1'b0));
        check("rst_ready_in", 256'(r14.readySamp_H), 256'(1'b1));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Basic and mask cases
        send_fixed(24'h000010, 24'h0, 24'h000014, 24'h000040);
        drain();
        send_fixed(24'h000080, 24'h0, 24'h0000A0, 24'h000200);
        drain();
        sub = 4'b0001;
        send_fixed(24'h000080, 24'h0, 24'h0000A0, 24'h000000);
        drain();
        sub = 4'b1000;

        // Seed load: same-cycle sample uses the old seed
        seed = 16'h0301;
        frame_start = 1'b1;
        send_fixed(24'h0, 24'h0, 24'h0, 24'h0);
        frame_start = 1'b0;
        send_fixed(24'h0, 24'h0, 24'h000004, 24'h00000C);
        drain();

        // Backpressure: 4 stalled cycles mid-stream
        run_stream(6, 3, 7, 1'b0);

        // Random streams across legal MSAA modes
        sub = 4'b1000; run_stream(40, 0, 0, 1'b1);
        sub = 4'b0100; run_stream(30, 0, 0, 1'b1);
        sub = 4'b0010; run_stream(30, 0, 0, 1'b1);
        sub = 4'b0001; run_stream(30, 0, 0, 1'b1);
        sub = 4'b1000;

        // Illegal mode and jitter disable
        sub = 4'b0110;
        send_fixed(24'h000010, 24'h0, 24'h000010, 24'h0);
        drain();
        check("mode_err_set", 256'(mode_err), 256'(1'b1));
        sub = 4'b1000;
        cycle();
        check("mode_err_sticky", 256'(mode_err), 256'(1'b1));
        jit_en = 1'b0;
        send_fixed(24'h000010, 24'h0, 24'h000010, 24'h0);
        drain();
        jit_en = 1'b1;

        // Reset with three samples in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            cycle();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 256'(o_valid), 256'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 256'(o_valid), 256'(1'b0));
        check("rst_async_s0", 256'(o_s0), 256'(0));
        check("rst_async_mode_err", 256'(mode_err), 256'(1'b0));
        q.delete();
        prev_stall = 1'b0;
        model_seed = '0;
        model_err = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 256'(r14.readySamp_H), 256'(1'b1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n_out = 0;
        repeat (6) cycle();
        check("no_ghost_out", 256'(n_out), 256'(0));

        // Seed register must have cleared: zero sample gives zero jitter
        send_fixed(24'h0, 24'h0, 24'h0, 24'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
